cnn_layer_accel_weight_sequence_gen: RTL and testbench

CNN_LAYER_ACCEL_WEIGHT_SEQUENCE_GEN -- requirements
Module: cnn_layer_accel_weight_sequence_gen

---
 rtl/cnn_layer_accel_weight_sequence_gen.sv | 134 +++++++++++++
 tb/tb_cnn_layer_accel_weight_sequence_gen.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/cnn_layer_accel_weight_sequence_gen.sv
// Weight sequence table address generator: walks (gray_code, sequence_selector, seq_data_addr)
// tuples, two sub-sequences of SEQ_LEN entries per output row, with downstream stall.
module cnn_layer_accel_weight_sequence_gen #(
  parameter int unsigned SEQ_LEN     = 5,
  parameter int unsigned C_ROW_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stall,
  input  logic [C_ROW_CNT_W-1:0] num_rows_cfg,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             gray_code,
  output logic                   sequence_selector,
  output logic [2:0]             seq_data_addr,
  output logic                   seq_valid
);

  localparam logic [2:0]             AddrLast = 3'(SEQ_LEN - 1);
  localparam logic [C_ROW_CNT_W-1:0] RowOne   = C_ROW_CNT_W'(1);

  typedef enum logic [1:0] {StIdle, StRun, StFinish} state_e;

  state_e                 state_q, state_d;
  logic [C_ROW_CNT_W-1:0] num_rows_q, num_rows_d;
  logic [C_ROW_CNT_W-1:0] row_cnt_q, row_cnt_d;
  logic [1:0]             gray_q, gray_d;
  logic                   sel_q, sel_d;
  logic [2:0]             addr_q, addr_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   last_beat;

  assign last_beat = (addr_q == AddrLast) && !sel_q && (row_cnt_q == num_rows_q - RowOne);

  // Tuple registers hold the next tuple to present; a valid beat is always consumed,
  // so the tuple advances on every valid beat and stall only withholds the next one.
  always_comb begin
    state_d    = state_q;
    num_rows_d = num_rows_q;
    row_cnt_d  = row_cnt_q;
    gray_d     = gray_q;
    sel_d      = sel_q;
    addr_d     = addr_q;
    valid_d    = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        busy_d = 1'b0;
        if (start) begin
          busy_d = 1'b1;
          gray_d = 2'b00;
          sel_d  = 1'b1;
          addr_d = 3'd0;
          if (num_rows_cfg != '0) begin
            num_rows_d = num_rows_cfg;
            row_cnt_d  = '0;
            valid_d    = 1'b1;
            state_d    = StRun;
          end else begin
            done_d  = 1'b1;
            state_d = StFinish;
          end
        end
      end
      StRun: begin
        if (!valid_q) begin
          valid_d = !stall;
        end else if (last_beat) begin
          done_d  = 1'b1;
          gray_d  = 2'b00;
          sel_d   = 1'b1;
          addr_d  = 3'd0;
          state_d = StFinish;
        end else begin
          valid_d = !stall;
          if (addr_q == AddrLast) begin
            addr_d = 3'd0;
            sel_d  = !sel_q;
            if (!sel_q) begin
              row_cnt_d = row_cnt_q + RowOne;
              gray_d    = {gray_q[0], !gray_q[1]};
            end
          end else begin
            addr_d = addr_q + 3'd1;
          end
        end
      end
      StFinish: begin
        busy_d  = 1'b0;
        gray_d  = 2'b00;
        sel_d   = 1'b1;
        addr_d  = 3'd0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      num_rows_q <= '0;
      row_cnt_q  <= '0;
      gray_q     <= 2'b00;
      sel_q      <= 1'b1;
      addr_q     <= 3'd0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      num_rows_q <= num_rows_d;
      row_cnt_q  <= row_cnt_d;
      gray_q     <= gray_d;
      sel_q      <= sel_d;
      addr_q     <= addr_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy              = busy_q;
  assign done              = done_q;
  assign gray_code         = gray_q;
  assign sequence_selector = sel_q;
  assign seq_data_addr     = addr_q;
  assign seq_valid         = valid_q;

endmodule

// File: tb/tb_cnn_layer_accel_weight_sequence_gen.sv
// Scoreboard bench: stimulus pushes expected tuples, a negedge monitor pops and compares.
module tb_cnn_layer_accel_weight_sequence_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stall;
  logic [7:0] num_rows_cfg;
  logic       busy, done, sequence_selector, seq_valid;
  logic [1:0] gray_code;
  logic [2:0] seq_data_addr;

  cnn_layer_accel_weight_sequence_gen #(
    .SEQ_LEN     (5),
    .C_ROW_CNT_W (8)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .stall             (stall),
    .num_rows_cfg      (num_rows_cfg),
    .busy              (busy),
    .done              (done),
    .gray_code         (gray_code),
    .sequence_selector (sequence_selector),
    .seq_data_addr     (seq_data_addr),
    .seq_valid         (seq_valid)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [5:0] exp_q[$];

  // Cumulative monitor counters; stimulus takes snapshots around each run.
  int mon_cyc = 0, mon_beats = 0, mon_busy = 0, mon_gap = 0, mon_done = 0, mon_done_at = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  always @(negedge clk) begin
    mon_cyc++;
    if (busy) mon_busy++;
    if (busy && !seq_valid && !done) mon_gap++;
    if (done) begin
      mon_done++;
      mon_done_at = mon_cyc;
    end
    if (seq_valid) begin
      mon_beats++;
      if (exp_q.size() == 0) begin
        check("unexpected_beat", int'({gray_code, sequence_selector, seq_data_addr}), -1);
      end else begin
        check("tuple", int'({gray_code, sequence_selector, seq_data_addr}),
              int'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int idle_vec();
    return int'({busy, done, seq_valid, gray_code, sequence_selector, seq_data_addr});
  endfunction

  task automatic push_rows(input int n);
    logic [1:0] gtab[4];
    gtab[0] = 2'b00; gtab[1] = 2'b01; gtab[2] = 2'b11; gtab[3] = 2'b10;
    for (int r = 0; r < n; r++)
      for (int h = 0; h < 2; h++)
        for (int a = 0; a < 5; a++)
          exp_q.push_back({gtab[r % 4], (h == 0) ? 1'b1 : 1'b0, 3'(a)});
  endtask

  // stall_at: first cycle (1 = first RUN cycle) of a 3-cycle stall; restart_at: cycle of a
  // spurious start with cfg 9; rst_at: cycle at which reset aborts the run. 0 disables each.
  task automatic run_case(input int n, input int stall_at, input int restart_at, input int rst_at);
    int c, b_cyc, b_beats, b_busy, b_gap, b_done, stalls, total;
    push_rows(n);
    start = 1'b1;
    num_rows_cfg = 8'(n);
    tick();
    start = 1'b0;
    num_rows_cfg = 8'hAA;
    b_cyc = mon_cyc; b_beats = mon_beats; b_busy = mon_busy; b_gap = mon_gap; b_done = mon_done;
    c = 1;
    while (mon_done == b_done && c < 6000) begin
      stall = (stall_at != 0 && c >= stall_at && c < stall_at + 3);
      start = (restart_at != 0 && c == restart_at);
      if (start) num_rows_cfg = 8'd9;
      if (rst_at != 0 && c == rst_at) begin
        rst = 1'b1;
        stall = 1'b1;
        tick();
        rst = 1'b0;
        stall = 1'b0;
        start = 1'b0;
        check("abort_outputs", idle_vec(), 9'b000001000);
        tick();
        check("abort_no_done", mon_done - b_done, 0);
        check("abort_beats", mon_beats - b_beats, rst_at);
        exp_q.delete();
        return;
      end
      tick();
      c++;
    end
    stall = 1'b0;
    start = 1'b0;
    stalls = (stall_at != 0) ? 3 : 0;
    total = 10 * n;
    check("done_pulses", mon_done - b_done, 1);
    check("done_cycle", mon_done_at - b_cyc, total + stalls + 1);
    check("busy_cycles", mon_busy - b_busy, total + stalls + 1);
    check("beats", mon_beats - b_beats, total);
    check("stall_gaps", mon_gap - b_gap, stalls);
    check("queue_left", exp_q.size(), 0);
    check("idle_after", idle_vec(), 9'b000001000);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    stall = 1'b1;
    num_rows_cfg = 8'd3;
    tick();
    tick();
    check("reset_outputs", idle_vec(), 9'b000001000);
    rst = 1'b0;
    stall = 1'b0;
    tick();
    check("idle_stall_ignored", idle_vec(), 9'b000001000);

    run_case(1, 0, 0, 0);
    run_case(5, 0, 0, 0);
    run_case(2, 3, 0, 0);
    run_case(0, 0, 0, 0);
    run_case(3, 0, 0, 7);
    run_case(3, 0, 0, 0);
    run_case(4, 0, 5, 0);
    run_case(255, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
